// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack
// Back end of the single-precision add/sub datapath. Takes the signed-magnitude
// mantissa sum and the common biased exponent, normalizes it one shift per
// cycle (round-to-nearest-even when shifting right), and packs an IEEE-754
// single-precision word with zero/overflow/underflow status.
// One operation is in flight at a time; both sides use valid/ready.

module fp_normalize_pack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [MANT_W-1:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-2:0]   result,
  output logic                      zero,
  output logic                      overflow,
  underflow
);

  // Fraction width excludes the carry bit and the hidden bit.
  localparam int FRAC_W = MANT_W - 2;

  // The working exponent carries one extra bit so that a second right shift
  // after reaching the all-ones exponent cannot wrap around.
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [MANT_W-1:0] MANT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t              state;
  logic                sign_q;
  logic [EXP_W:0]      exp_q;
  logic [MANT_W-1:0]   mant_q;
  logic [MANT_W-1:0]   round_inc;

  // Halving an odd mantissa leaves exactly one bit behind; rounding the tie to
  // even means bumping only when the surviving lsb would otherwise be odd.
  assign round_inc = {{(MANT_W-1){1'b0}}, mant_q[0] & mant_q[1]};

  // Handshake, iterative normalization and packing, all with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_sign;
            exp_q     <= {1'b0, in_exp};
            mant_q    <= in_mant;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            in_ready  <= 1'b0;
            if (in_exp == {EXP_W{1'b1}}) begin
              result    <= {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              overflow  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mant_q == MANT_ZERO) begin
            // Exact cancellation always yields +0 regardless of sign.
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant_q[MANT_W-1]) begin
            // Carry out of the adder: halve with rounding. A rounded value of
            // 2^24 is caught by this same branch on the next cycle.
            mant_q <= (mant_q >> 1) + round_inc;
            exp_q  <= exp_q + EXP_ONE;
          end else if (exp_q >= EXP_INF) begin
            result    <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            overflow  <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!mant_q[MANT_W-2] && (exp_q > EXP_ONE)) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end else if (!mant_q[MANT_W-2]) begin
            // Exponent floor reached with no hidden bit: denormal encoding.
            result    <= {sign_q, {EXP_W{1'b0}}, mant_q[FRAC_W-1:0]};
            underflow <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            result    <= {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Back end of the FP add/sub datapath: consumes the 25-bit signed-magnitude mantissa result and result sign from the mantissa adder, together with the common (larger) biased exponent.
- Normalizes iteratively, one shift per cycle, with round-to-nearest-even on right shift.
- Packs an IEEE-754 single-precision word with status flags.
- valid/ready handshake on both sides; one operation in flight.

Parameters:
- EXP_W, 8, biased exponent width
- MANT_W, 25, input mantissa width (carry bit + hidden bit + 23 fraction bits)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input operands valid
- in_ready  output  1  block can accept; high only in IDLE
- in_sign  input  1  result sign from adder
- in_exp  input  8  biased exponent, legal 1..255 (denormal inputs are encoded as 1)
- in_mant  input  25  adder magnitude; value = in_mant * 2^(in_exp-150)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  32  packed {sign, exp[7:0], frac[22:0]}
- zero  output  1  result is exactly zero
- overflow  output  1  result is infinity
- underflow  output  1  result is denormal (nonzero)

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0. Reset asserted in any state aborts the operation; no output is produced.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register sign, exp (9-bit internal) and mant, then go to NORM.
  - If in_exp==255, go directly to DONE with infinity: result={sign,8'hFF,0}, overflow=1.
- NORM, evaluated each cycle in this priority order:
  - mant==0: result=32'h00000000 (always +0, sign ignored), zero=1, go to DONE.
  - mant[24]==1: mant=(mant>>1)+(mant[0]&mant[1]), exp=exp+1, stay in NORM. This is the tie-to-even case; only one bit is shifted out, so there is no sticky bit. If the rounded value reaches 2^24, the next NORM cycle shifts again.
  - exp==255 after an increment: result={sign,8'hFF,23'h0}, overflow=1, go to DONE. This check takes priority over further shifting.
  - mant[23]==0 and exp>1: mant=mant<<1, exp=exp-1, stay in NORM.
  - mant[23]==0 and exp==1: denormal. result={sign,8'h00,mant[22:0]}, underflow=1, go to DONE.
  - Otherwise: result={sign,exp[7:0],mant[22:0]}, go to DONE.
- DONE:
  - out_valid=1; result and flags held stable until out_ready.
  - On out_valid&&out_ready: out_valid drops next cycle, state returns to IDLE, in_ready=1.
  - No same-cycle re-accept: in_ready stays 0 while in DONE.
- Latency (accept edge = cycle 0):
  - Already normalized input: out_valid at cycle 2.
  - Each right or left shift adds 1 cycle.
  - Worst case is bounded by the exponent range (at most 24 shifts).
  - The exp==255 fast path gives out_valid at cycle 1.
- Flags are mutually exclusive and are cleared when a new operation is accepted.
- Inputs are ignored outside IDLE.

Test Plan:
- Carry case: sign=0, exp=127, mant=25'h1000000 → one right shift; out_valid at cycle 3; result=32'h40000000; all flags 0.
- Cancellation: exp=127, mant=25'h0200000 → two left shifts; out_valid at cycle 4; result=32'h3E800000.
- Rounding:
  - exp=127, mant=25'h1000003 → result=32'h40000002 (tie rounds up to even).
  - mant=25'h1000001 → result=32'h40000000 (tie stays even).
- Special results:
  - mant=0, sign=1 → result=32'h00000000, zero=1.
  - exp=254, mant=25'h1000000 → result=32'h7F800000, overflow=1.
  - exp=3, mant=25'h0000100 → two shifts, then result=32'h00000400, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0; an in_valid pulse during this time is ignored; release out_ready → IDLE next cycle.
- Reset mid-operation: assert rst during NORM of the cancellation case → out_valid=0, result=0, in_ready=1 immediately (asynchronous); a following normal operation completes correctly.
